snn_input_loader: RTL
=====================

// Module: snn_input_loader
// PURPOSE
//  Parametrised, double-buffered successor to the single-image input loader. Packs
//  bytes strobed in from the UART receiver into a bit-addressable image bank, LSB first.
//  Two banks (ping-pong): the SNN core reads image N while image N+1 loads.
//  The core returns a bank with a release pulse.
// PARAMETERS
//  NUM_BITS    784   image size in bits (28x28)
//  BYTE_W      8     width of each received data word
//  ADDR_W      10    bit-address width; must satisfy 2**ADDR_W >= NUM_BITS
//  TIMEOUT_CYC 5000  idle cycles before a partial frame is discarded (SNN_LOADER_TIMEOUT_EN only)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  trigger     in   1       one-cycle strobe; data valid in the same cycle
//  data        in   BYTE_W  received word
//  release     in   1       one-cycle pulse from the core; frees the current read bank
//  addr        in   ADDR_W  bit address into the read bank
//  q           out  1       image bit at addr; 1-cycle latency
//  ready       out  1       read bank holds a complete image
//  frame_done  out  1       one-cycle pulse when a frame finishes loading
//  overflow    out  1       sticky; a word arrived while both banks were full
//  timeout_err out  1       one-cycle pulse when a partial frame is dropped
// BEHAVIOUR
//  Reset state: q=0, ready=0, frame_done=0, overflow=0, timeout_err=0.
//   Both full flags=0, wr_bank=0, rd_bank=0, byte_cnt=0, state=FILL. Bank contents are not reset.
//  NBYTES = ceil(NUM_BITS/BYTE_W), which is 98 at the defaults.
//  Write FSM, FILL state, on trigger:
//   - bits [byte_cnt*BYTE_W +: BYTE_W] of bank wr_bank <= data, with data[0] at the lowest address.
//   - Bits at or beyond NUM_BITS in the last word are discarded.
//   - byte_cnt increments.
//  Frame completion, on the trigger that carries word NBYTES-1:
//   - full[wr_bank] <= 1; frame_done pulses the next cycle; byte_cnt <= 0; wr_bank toggles.
//   - If full[~wr_bank] is already set, the next state is WAIT.
//  WAIT state: triggers are dropped and overflow is set (sticky until rst).
//   WAIT -> FILL in the cycle after full[wr_bank] clears.
//  Read side:
//   - ready = full[rd_bank], registered.
//   - q <= bank[rd_bank][addr] every cycle; q = 0 when addr >= NUM_BITS.
//   - q is undefined-free but meaningless while ready = 0.
//  release while ready = 1: full[rd_bank] <= 0 and rd_bank toggles. release while ready = 0 is ignored.
//  release and frame completion in the same cycle: both take effect, no loss.
//   If this frees the bank being written next, the FSM stays in FILL and does not enter WAIT.
//  rst mid-frame: the partial frame and both full flags are lost; loading restarts at bank 0, byte 0.
//  First ready rises 2 cycles after the trigger of word NBYTES-1.
// CONFIGURATION
//  SNN_LOADER_TIMEOUT_EN defined:
//   - An idle counter runs while in FILL with byte_cnt != 0; trigger clears it.
//   - When the counter reaches TIMEOUT_CYC: byte_cnt <= 0, timeout_err pulses for 1 cycle, bank flags are untouched.
//  SNN_LOADER_TIMEOUT_EN undefined: no counter is built, timeout_err is tied 0, and a partial frame waits indefinitely.
// STRUCTURE
//  Package snn_loader_pkg holds:
//   - typedef enum logic {FILL, WAIT} loader_state_t
//   - default constants IMG_BITS=784 and UART_BYTE_W=8
//   - function nbytes(bits, w) returning the ceil division
//  Sub-module snn_loader_bank, instantiated twice:
//   - NUM_BITS x 1 storage, BYTE_W-wide word write (we, word index), 1-bit registered read.
//   - Top-level muxes the two bank outputs by rd_bank.
// TESTING
//  1. Send 98 words of 8'hFF.
//     -> ready=0 through word 97; frame_done pulses once; ready=1 two cycles later.
//     -> q=1 for addr 0..783; q=0 at addr 784.
//  2. Send a 98-word frame of 8'b10010011.
//     -> q at addr 0..7 reads 1,1,0,0,1,0,0,1 and repeats every 8 addresses.
//  3. Load frame A (8'h00), then frame B (8'hFF) with no release in between.
//     -> ready stays 1 and q=0 throughout.
//     -> Pulse release: q=1 at addr 0 after 2 cycles.
//     -> Pulse release again: ready=0.
//  4. Load A and B, then send a 99th word.
//     -> overflow=1 and the word is dropped.
//     -> After release, a new 98-word frame loads and ready stays 1.
//  5. Assert release in the same cycle as the last word of frame B while A is held.
//     -> A is freed, B becomes readable, and the FSM remains in FILL.
//  6. With SNN_LOADER_TIMEOUT_EN, TIMEOUT_CYC=100: send 10 words, then idle 100 cycles.
//     -> timeout_err pulses once.
//     -> A following 98-word frame gives ready=1 with correct data.
//  7. Assert rst after word 50.
//     -> All outputs return to reset values.
//     -> A fresh 98-word frame loads correctly.

Source files
------------

// File: rtl/snn_loader_pkg.sv
// Shared types, defaults and helpers for the double-buffered SNN input loader.
package snn_loader_pkg;

    typedef enum logic {FILL, WAIT} loader_state_t;

    localparam int IMG_BITS    = 784;
    localparam int UART_BYTE_W = 8;

    // Number of BYTE_W-wide words needed to cover an image of the given size.
    function automatic int nbytes(input int bits, input int w);
        return (bits + w - 1) / w;
    endfunction

endpackage

// File: rtl/snn_input_loader_if.sv
// Byte-load / bit-read bus of the SNN input loader; master is the UART/core side, slave the loader.
interface snn_input_loader_if #(
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 10
);
    logic              trigger;
    logic [BYTE_W-1:0] data;
    logic              bank_release;
    logic [ADDR_W-1:0] addr;
    logic              q;
    logic              ready;
    logic              frame_done;
    logic              overflow;
    logic              timeout_err;

    modport master (
        output trigger, data, bank_release, addr,
        input  q, ready, frame_done, overflow, timeout_err
    );

    modport slave (
        input  trigger, data, bank_release, addr,
        output q, ready, frame_done, overflow, timeout_err
    );
endinterface

// File: rtl/snn_loader_bank.sv
// One image bank: NUM_BITS bits written a BYTE_W word at a time, read one bit per cycle (registered).
module snn_loader_bank
    import snn_loader_pkg::*;
#(
    parameter int NUM_BITS = IMG_BITS,
    parameter int BYTE_W   = UART_BYTE_W,
    parameter int ADDR_W   = 10,
    parameter int IDX_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BYTE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] addr,
    output logic              q
);
    localparam int NBYTES    = nbytes(NUM_BITS, BYTE_W);
    localparam int BIT_W     = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam int TAIL_BITS = NUM_BITS - (NBYTES - 1) * BYTE_W;
    localparam logic [BYTE_W-1:0] TAIL_MASK = {BYTE_W{1'b1}} >> (BYTE_W - TAIL_BITS);

    logic [BYTE_W-1:0] mem [NBYTES];
    logic [IDX_W-1:0]  word_sel;
    logic [BIT_W-1:0]  bit_sel;

    assign word_sel = IDX_W'(addr / ADDR_W'(BYTE_W));
    assign bit_sel  = BIT_W'(addr % ADDR_W'(BYTE_W));

    // Image storage is deliberately left unreset; bits past NUM_BITS in the last word are dropped.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= (idx == IDX_W'(NBYTES - 1)) ? (wdata & TAIL_MASK) : wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= (int'(addr) < NUM_BITS) ? mem[word_sel][bit_sel] : 1'b0;
        end
    end

endmodule

// File: rtl/snn_input_loader.sv
// Ping-pong SNN image loader: packs UART words LSB-first into two bit banks while the core reads the other.
// Define SNN_LOADER_TIMEOUT_EN to build the idle timeout that discards stalled partial frames.
module snn_input_loader
    import snn_loader_pkg::*;
#(
    parameter int NUM_BITS    = IMG_BITS,
    parameter int BYTE_W      = UART_BYTE_W,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 5000
) (
    input logic               clk,
    input logic               rst,
    snn_input_loader_if.slave bus
);
    localparam int NBYTES = nbytes(NUM_BITS, BYTE_W);
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    if (2 ** ADDR_W < NUM_BITS) begin : g_bad_addr_w
        $error("snn_input_loader: ADDR_W cannot address NUM_BITS");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("snn_input_loader: TIMEOUT_CYC must be at least 1");
    end

    loader_state_t    state;
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic             wr_bank;
    logic             rd_bank;
    logic             rd_bank_d;
    logic [CNT_W-1:0] byte_cnt;
    logic             ready_r;
    logic             frame_done_r;
    logic             overflow_r;
    logic             timeout_err_r;
    logic             write_acc;
    logic             last_word;
    logic             rel_acc;
    logic             timeout_hit;
    logic             q0;
    logic             q1;

    assign write_acc = bus.trigger && (state == FILL);
    assign last_word = write_acc && (byte_cnt == CNT_W'(NBYTES - 1));
    // Gating on full[rd_bank] too stops a release in the cycle ready lags behind from freeing a bank twice.
    assign rel_acc   = bus.bank_release && ready_r && full[rd_bank];

    always_comb begin
        full_next = full;
        if (rel_acc) begin
            full_next[rd_bank] = 1'b0;
        end
        if (last_word) begin
            full_next[wr_bank] = 1'b1;
        end
    end

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_hit = (state == FILL) && !bus.trigger && (byte_cnt != '0)
                         && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (bus.trigger || timeout_hit || (state != FILL) || (byte_cnt == '0)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Write FSM plus bank bookkeeping; the new state is chosen from full_next so a release
    // landing with frame completion keeps loading instead of stalling in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            full          <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            rd_bank_d     <= 1'b0;
            byte_cnt      <= '0;
            ready_r       <= 1'b0;
            frame_done_r  <= 1'b0;
            overflow_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            full          <= full_next;
            ready_r       <= full[rd_bank];
            rd_bank_d     <= rd_bank;
            frame_done_r  <= last_word;
            timeout_err_r <= timeout_hit;
            if (rel_acc) begin
                rd_bank <= ~rd_bank;
            end
            case (state)
                FILL: begin
                    if (write_acc) begin
                        if (last_word) begin
                            byte_cnt <= '0;
                            wr_bank  <= ~wr_bank;
                            if (full_next[~wr_bank]) begin
                                state <= WAIT;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        byte_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (bus.trigger) begin
                        overflow_r <= 1'b1;
                    end
                    if (!full[wr_bank]) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    snn_loader_bank #(
        .NUM_BITS(NUM_BITS), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .IDX_W(CNT_W)
    ) u_bank0 (
        .clk(clk), .rst(rst), .we(write_acc && !wr_bank), .idx(byte_cnt),
        .wdata(bus.data), .addr(bus.addr), .q(q0)
    );

    snn_loader_bank #(
        .NUM_BITS(NUM_BITS), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .IDX_W(CNT_W)
    ) u_bank1 (
        .clk(clk), .rst(rst), .we(write_acc && wr_bank), .idx(byte_cnt),
        .wdata(bus.data), .addr(bus.addr), .q(q1)
    );

    assign bus.q           = rd_bank_d ? q1 : q0;
    assign bus.ready       = ready_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.overflow    = overflow_r;
    assign bus.timeout_err = timeout_err_r;

endmodule
